// File: rtl/reg_dump_reader.sv
// reg_dump_reader: streams a framed register-file dump (sync byte, hi/lo bytes per register) over a valid/ready byte link
// Ports: clk, reset (sync active-low), i_start (begin dump when idle), o_read_add/i_read_data (register-file read port),
//        o_tx_data/o_tx_valid/i_tx_ready (byte stream to UART TX), o_busy (dump in progress), o_done (final byte accepted).
// Optional: define REG_DUMP_CHECKSUM_EN to append an XOR checksum of all register data bytes to the frame.
module reg_dump_reader #(
  parameter int NUM_REGS = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  output logic [3:0]  o_read_add,
  input  logic [15:0] i_read_data,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  output logic        o_busy,
  output logic        o_done
);
  typedef enum logic [2:0] {
    IDLE, HDR, LATCH, SEND_HI, SEND_LO
`ifdef REG_DUMP_CHECKSUM_EN
    , CHK
`endif
  } state_t;
  state_t state, next;
  logic [3:0] idx;
  logic [15:0] shadow;
  logic acc, last;
  assign acc = o_tx_valid & i_tx_ready;
  assign last = idx == 4'(NUM_REGS - 1);
  always_ff @(posedge clk)
    if (!reset) state <= IDLE;
    else state <= next;
  // idx doubles as the registered read address; it wraps to 0 after the last register so IDLE always sees 0
  always_ff @(posedge clk)
    if (!reset) begin
      idx <= 4'd0;
      shadow <= 16'h0000;
    end else begin
      if (state == LATCH) shadow <= i_read_data;
      if (state == SEND_LO && acc) idx <= last ? 4'd0 : idx + 4'd1;
    end
`ifdef REG_DUMP_CHECKSUM_EN
  logic [7:0] checksum;
  always_ff @(posedge clk)
    if (!reset) checksum <= 8'h00;
    else if (acc) checksum <= state == HDR ? 8'h00 : state == CHK ? checksum : checksum ^ o_tx_data;
`endif
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = i_start ? HDR : IDLE;
      HDR:     next = acc ? LATCH : HDR;
      LATCH:   next = SEND_HI;
      SEND_HI: next = acc ? SEND_LO : SEND_HI;
`ifdef REG_DUMP_CHECKSUM_EN
      SEND_LO: next = !acc ? SEND_LO : last ? CHK : LATCH;
      CHK:     next = acc ? IDLE : CHK;
`else
      SEND_LO: next = !acc ? SEND_LO : last ? IDLE : LATCH;
`endif
      default: next = IDLE;
    endcase
  end
  always_comb begin
    o_read_add = idx;
    o_busy = state != IDLE;
`ifdef REG_DUMP_CHECKSUM_EN
    o_tx_valid = state == HDR || state == SEND_HI || state == SEND_LO || state == CHK;
    o_tx_data = state == HDR ? SYNC_BYTE : state == SEND_HI ? shadow[15:8] : state == SEND_LO ? shadow[7:0] :
                state == CHK ? checksum : 8'h00;
    o_done = acc && state == CHK;
`else
    o_tx_valid = state == HDR || state == SEND_HI || state == SEND_LO;
    o_tx_data = state == HDR ? SYNC_BYTE : state == SEND_HI ? shadow[15:8] : state == SEND_LO ? shadow[7:0] : 8'h00;
    o_done = acc && state == SEND_LO && last;
`endif
  end
endmodule
